// File: rtl/video_lock_ctrl.sv
// Video format lock sequencer: NO_SIG/ACQ/LOCKED with debounced latched format.
// Define VIDEO_LOCK_TOL_EN to accept +/-1 jitter on the line and frame totals.
module video_lock_ctrl #(
   parameter logic [3:0]  P_LOCK_FRAMES   = 4'd4,
   parameter logic [3:0]  P_UNLOCK_FRAMES = 4'd2,
   parameter logic [25:0] P_TIMEOUT_CLKS  = 26'd3_000_000,
   parameter logic [12:0] P_MIN_HS        = 13'd100
) (
   input  logic        i_video_clk,
   input  logic        i_rst_n,
   input  logic        i_frame_stb,
   input  logic [12:0] i_hs_total,
   input  logic [12:0] i_vs_total,
   input  logic [12:0] i_start_pixel,
   input  logic [12:0] i_end_pixel,
   input  logic [12:0] i_start_h,
   input  logic [12:0] i_end_h,
   output logic [1:0]  o_state,
   output logic        o_locked,
   output logic        o_no_signal,
   output logic        o_fmt_change,
   output logic [12:0] o_hs_total_lk,
   output logic [12:0] o_vs_total_lk,
   output logic [12:0] o_active_w,
   output logic [12:0] o_active_h
);

   typedef enum logic [1:0] {
      ST_NO_SIG = 2'b00,
      ST_ACQ    = 2'b01,
      ST_LOCKED = 2'b10
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  match_q, match_d;
   logic [3:0]  miss_q, miss_d;
   logic [12:0] cand_hs_q, cand_hs_d;
   logic [12:0] cand_vs_q, cand_vs_d;
   logic [12:0] cand_w_q, cand_w_d;
   logic [12:0] cand_h_q, cand_h_d;
   logic [12:0] hs_lk_q, hs_lk_d;
   logic [12:0] vs_lk_q, vs_lk_d;
   logic [12:0] w_lk_q, w_lk_d;
   logic [12:0] h_lk_q, h_lk_d;
   logic [25:0] tmo_q, tmo_d;
   logic        fmt_q, fmt_d;
   logic        has_lock_q, has_lock_d;

   logic [12:0] w, h;
   logic [12:0] ref_hs, ref_vs, ref_w, ref_h;
   logic        hs_eq, vs_eq;
   logic        frame_valid, frame_match, expire;
   logic [3:0]  match_inc, miss_inc;

   assign w = i_end_pixel - i_start_pixel;
   assign h = i_end_h - i_start_h;

   assign frame_valid = (i_hs_total >= P_MIN_HS) &&
                        (i_vs_total != 13'd0) &&
                        (i_end_pixel > i_start_pixel) &&
                        (i_end_h > i_start_h);

   assign ref_hs = (state_q == ST_LOCKED) ? hs_lk_q : cand_hs_q;
   assign ref_vs = (state_q == ST_LOCKED) ? vs_lk_q : cand_vs_q;
   assign ref_w  = (state_q == ST_LOCKED) ? w_lk_q  : cand_w_q;
   assign ref_h  = (state_q == ST_LOCKED) ? h_lk_q  : cand_h_q;

`ifdef VIDEO_LOCK_TOL_EN
   function automatic logic near(input logic [12:0] a, input logic [12:0] b);
      logic [13:0] d;
      d = {1'b0, a} - {1'b0, b};
      return (d == 14'd0) || (d == 14'd1) || (d == 14'h3FFF);
   endfunction

   assign hs_eq = near(i_hs_total, ref_hs);
   assign vs_eq = near(i_vs_total, ref_vs);
`else
   assign hs_eq = (i_hs_total == ref_hs);
   assign vs_eq = (i_vs_total == ref_vs);
`endif

   assign frame_match = frame_valid && hs_eq && vs_eq &&
                        (w == ref_w) && (h == ref_h);

   assign match_inc = (match_q == 4'hF) ? 4'hF : match_q + 4'd1;
   assign miss_inc  = (miss_q == 4'hF) ? 4'hF : miss_q + 4'd1;

   // A strobe in the expiry cycle always wins over the timeout.
   assign expire = !i_frame_stb && (tmo_q >= P_TIMEOUT_CLKS - 26'd1);

   always_comb begin
      if (i_frame_stb)
         tmo_d = '0;
      else if (tmo_q >= P_TIMEOUT_CLKS)
         tmo_d = tmo_q;
      else
         tmo_d = tmo_q + 26'd1;
   end

   always_comb begin
      state_d    = state_q;
      match_d    = match_q;
      miss_d     = miss_q;
      cand_hs_d  = cand_hs_q;
      cand_vs_d  = cand_vs_q;
      cand_w_d   = cand_w_q;
      cand_h_d   = cand_h_q;
      hs_lk_d    = hs_lk_q;
      vs_lk_d    = vs_lk_q;
      w_lk_d     = w_lk_q;
      h_lk_d     = h_lk_q;
      fmt_d      = 1'b0;
      has_lock_d = has_lock_q;

      if (expire) begin
         state_d = ST_NO_SIG;
         match_d = '0;
         miss_d  = '0;
      end else if (i_frame_stb) begin
         unique case (state_q)
            ST_NO_SIG: begin
               if (frame_valid) begin
                  cand_hs_d = i_hs_total;
                  cand_vs_d = i_vs_total;
                  cand_w_d  = w;
                  cand_h_d  = h;
                  match_d   = 4'd1;
                  state_d   = ST_ACQ;
                  if (4'd1 >= P_LOCK_FRAMES) begin
                     state_d = ST_LOCKED;
                     hs_lk_d = i_hs_total;
                     vs_lk_d = i_vs_total;
                     w_lk_d  = w;
                     h_lk_d  = h;
                     match_d = '0;
                     miss_d  = '0;
                  end
               end
            end
            ST_ACQ: begin
               if (frame_match) begin
                  match_d = match_inc;
                  if (match_inc >= P_LOCK_FRAMES) begin
                     state_d = ST_LOCKED;
                     hs_lk_d = cand_hs_q;
                     vs_lk_d = cand_vs_q;
                     w_lk_d  = cand_w_q;
                     h_lk_d  = cand_h_q;
                     match_d = '0;
                     miss_d  = '0;
                  end
               end else if (frame_valid) begin
                  cand_hs_d = i_hs_total;
                  cand_vs_d = i_vs_total;
                  cand_w_d  = w;
                  cand_h_d  = h;
                  match_d   = 4'd1;
                  if (4'd1 >= P_LOCK_FRAMES) begin
                     state_d = ST_LOCKED;
                     hs_lk_d = i_hs_total;
                     vs_lk_d = i_vs_total;
                     w_lk_d  = w;
                     h_lk_d  = h;
                     match_d = '0;
                     miss_d  = '0;
                  end
               end else begin
                  match_d   = '0;
                  cand_hs_d = '0;
                  cand_vs_d = '0;
                  cand_w_d  = '0;
                  cand_h_d  = '0;
               end
            end
            ST_LOCKED: begin
               if (frame_match) begin
                  miss_d = '0;
               end else if (miss_inc >= P_UNLOCK_FRAMES) begin
                  state_d = ST_ACQ;
                  miss_d  = '0;
                  if (frame_valid) begin
                     cand_hs_d = i_hs_total;
                     cand_vs_d = i_vs_total;
                     cand_w_d  = w;
                     cand_h_d  = h;
                     match_d   = 4'd1;
                  end else begin
                     cand_hs_d = '0;
                     cand_vs_d = '0;
                     cand_w_d  = '0;
                     cand_h_d  = '0;
                     match_d   = '0;
                  end
               end else begin
                  miss_d = miss_inc;
               end
            end
            default: begin
               state_d = ST_NO_SIG;
               match_d = '0;
               miss_d  = '0;
            end
         endcase
      end

      // Reconfigure downstream only when the locked format actually changes.
      if (state_d == ST_LOCKED && state_q != ST_LOCKED) begin
         fmt_d = !has_lock_q ||
                 (hs_lk_d != hs_lk_q) || (vs_lk_d != vs_lk_q) ||
                 (w_lk_d != w_lk_q) || (h_lk_d != h_lk_q);
         has_lock_d = 1'b1;
      end
   end

   always_ff @(posedge i_video_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= ST_NO_SIG;
         match_q    <= '0;
         miss_q     <= '0;
         cand_hs_q  <= '0;
         cand_vs_q  <= '0;
         cand_w_q   <= '0;
         cand_h_q   <= '0;
         hs_lk_q    <= '0;
         vs_lk_q    <= '0;
         w_lk_q     <= '0;
         h_lk_q     <= '0;
         tmo_q      <= '0;
         fmt_q      <= 1'b0;
         has_lock_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         match_q    <= match_d;
         miss_q     <= miss_d;
         cand_hs_q  <= cand_hs_d;
         cand_vs_q  <= cand_vs_d;
         cand_w_q   <= cand_w_d;
         cand_h_q   <= cand_h_d;
         hs_lk_q    <= hs_lk_d;
         vs_lk_q    <= vs_lk_d;
         w_lk_q     <= w_lk_d;
         h_lk_q     <= h_lk_d;
         tmo_q      <= tmo_d;
         fmt_q      <= fmt_d;
         has_lock_q <= has_lock_d;
      end
   end

   assign o_state       = state_q;
   assign o_locked      = (state_q == ST_LOCKED);
   assign o_no_signal   = (state_q == ST_NO_SIG);
   assign o_fmt_change  = fmt_q;
   assign o_hs_total_lk = hs_lk_q;
   assign o_vs_total_lk = vs_lk_q;
   assign o_active_w    = w_lk_q;
   assign o_active_h    = h_lk_q;

endmodule

// File: tb/tb_video_lock_ctrl.sv
// Directed table-driven bench for video_lock_ctrl with hand sequences
// for timeout, strobe/expiry collision, async reset and total jitter.
module tb_video_lock_ctrl;

   localparam int TMO = 50;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stb = 1'b0;
   logic [12:0] hs = '0, vs = '0, sp = '0, ep = '0, sh = '0, eh = '0;
   logic [1:0]  st;
   logic        locked, no_sig, fc;
   logic [12:0] hl, vl, wl, hlk;

   int errors = 0;
   int checks = 0;

   video_lock_ctrl #(
      .P_LOCK_FRAMES   (4'd4),
      .P_UNLOCK_FRAMES (4'd2),
      .P_TIMEOUT_CLKS  (26'(TMO)),
      .P_MIN_HS        (13'd100)
   ) dut (
      .i_video_clk   (clk),
      .i_rst_n       (rst_n),
      .i_frame_stb   (stb),
      .i_hs_total    (hs),
      .i_vs_total    (vs),
      .i_start_pixel (sp),
      .i_end_pixel   (ep),
      .i_start_h     (sh),
      .i_end_h       (eh),
      .o_state       (st),
      .o_locked      (locked),
      .o_no_signal   (no_sig),
      .o_fmt_change  (fc),
      .o_hs_total_lk (hl),
      .o_vs_total_lk (vl),
      .o_active_w    (wl),
      .o_active_h    (hlk)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [12:0] hs, vs, sp, ep, sh, eh;
      logic [1:0]  st;
      logic        fc;
      logic [1:0]  lk;
   } vec_t;

   vec_t tbl[30];

   function automatic vec_t mk(input int f, input logic [1:0] s,
                               input logic c, input logic [1:0] l);
      vec_t v;
      v.hs = 13'd2200; v.vs = 13'd1125;
      v.sp = 13'd192;  v.ep = 13'd2112;
      v.sh = 13'd41;   v.eh = 13'd1121;
      if (f == 1) v.hs = 13'd1650;
      if (f == 2) begin
         v.hs = 13'd1650; v.vs = 13'd750;
         v.sp = 13'd260;  v.ep = 13'd1540;
         v.sh = 13'd25;   v.eh = 13'd745;
      end
      if (f == 3) v.ep = 13'd100;
      v.st = s; v.fc = c; v.lk = l;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [1:0] es,
                          input logic ef, input logic [1:0] el);
      logic [12:0] eh_, ev_, ew_, ea_;
      eh_ = '0; ev_ = '0; ew_ = '0; ea_ = '0;
      if (el == 2'd1) begin
         eh_ = 13'd2200; ev_ = 13'd1125; ew_ = 13'd1920; ea_ = 13'd1080;
      end else if (el == 2'd2) begin
         eh_ = 13'd1650; ev_ = 13'd750; ew_ = 13'd1280; ea_ = 13'd720;
      end
      chk({tag, " state"}, 32'(st), 32'(es));
      chk({tag, " locked"}, 32'(locked), 32'(es == 2'd2));
      chk({tag, " no_signal"}, 32'(no_sig), 32'(es == 2'd0));
      chk({tag, " fmt_change"}, 32'(fc), 32'(ef));
      chk({tag, " hs_lk"}, 32'(hl), 32'(eh_));
      chk({tag, " vs_lk"}, 32'(vl), 32'(ev_));
      chk({tag, " w"}, 32'(wl), 32'(ew_));
      chk({tag, " h"}, 32'(hlk), 32'(ea_));
   endtask

   task automatic strobe(input logic [12:0] a, input logic [12:0] b,
                         input logic [12:0] c, input logic [12:0] d,
                         input logic [12:0] e, input logic [12:0] f);
      hs = a; vs = b; sp = c; ep = d; sh = e; eh = f;
      stb = 1'b1;
      @(posedge clk);
      #1;
      stb = 1'b0;
   endtask

   task automatic strobe_a(input logic [12:0] a);
      strobe(a, 13'd1125, 13'd192, 13'd2112, 13'd41, 13'd1121);
   endtask

   task automatic run_rows(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         repeat (2) @(posedge clk);
         #1;
         strobe(tbl[i].hs, tbl[i].vs, tbl[i].sp,
                tbl[i].ep, tbl[i].sh, tbl[i].eh);
         chk_all($sformatf("row%0d", i), tbl[i].st, tbl[i].fc, tbl[i].lk);
      end
   endtask

   task automatic do_reset();
      #3;
      rst_n = 1'b0;
      #1;
      chk_all("async_reset", 2'd0, 1'b0, 2'd0);
      #3;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = mk(0, 2'd1, 1'b0, 2'd0);
      tbl[1]  = mk(0, 2'd1, 1'b0, 2'd0);
      tbl[2]  = mk(0, 2'd1, 1'b0, 2'd0);
      tbl[3]  = mk(0, 2'd2, 1'b1, 2'd1);
      tbl[4]  = mk(1, 2'd2, 1'b0, 2'd1);
      tbl[5]  = mk(0, 2'd2, 1'b0, 2'd1);
      tbl[6]  = mk(2, 2'd2, 1'b0, 2'd1);
      tbl[7]  = mk(2, 2'd1, 1'b0, 2'd1);
      tbl[8]  = mk(2, 2'd1, 1'b0, 2'd1);
      tbl[9]  = mk(2, 2'd1, 1'b0, 2'd1);
      tbl[10] = mk(2, 2'd2, 1'b1, 2'd2);
      tbl[11] = mk(0, 2'd2, 1'b0, 2'd2);
      tbl[12] = mk(0, 2'd1, 1'b0, 2'd2);
      tbl[13] = mk(0, 2'd1, 1'b0, 2'd2);
      tbl[14] = mk(0, 2'd1, 1'b0, 2'd2);
      tbl[15] = mk(0, 2'd2, 1'b1, 2'd1);
      tbl[16] = mk(0, 2'd1, 1'b0, 2'd1);
      tbl[17] = mk(0, 2'd1, 1'b0, 2'd1);
      tbl[18] = mk(0, 2'd1, 1'b0, 2'd1);
      tbl[19] = mk(0, 2'd2, 1'b0, 2'd1);
      tbl[20] = mk(3, 2'd2, 1'b0, 2'd1);
      tbl[21] = mk(3, 2'd1, 1'b0, 2'd1);
      tbl[22] = mk(0, 2'd1, 1'b0, 2'd1);
      tbl[23] = mk(0, 2'd1, 1'b0, 2'd1);
      tbl[24] = mk(0, 2'd1, 1'b0, 2'd1);
      tbl[25] = mk(3, 2'd1, 1'b0, 2'd1);
      tbl[26] = mk(0, 2'd1, 1'b0, 2'd1);
      tbl[27] = mk(0, 2'd1, 1'b0, 2'd1);
      tbl[28] = mk(0, 2'd1, 1'b0, 2'd1);
      tbl[29] = mk(0, 2'd2, 1'b0, 2'd1);

      repeat (3) @(posedge clk);
      #1;
      chk_all("reset", 2'd0, 1'b0, 2'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      strobe_a(13'd99);
      chk("min_hs_99 state", 32'(st), 32'd0);
      strobe(13'd2200, 13'd0, 13'd192, 13'd2112, 13'd41, 13'd1121);
      chk("vs_zero state", 32'(st), 32'd0);
      strobe_a(13'd100);
      chk("min_hs_100 state", 32'(st), 32'd1);

      run_rows(0, 15);

      repeat (TMO - 1) @(posedge clk);
      #1;
      chk("tmo_before locked", 32'(locked), 32'd1);
      @(posedge clk);
      #1;
      chk_all("tmo_at", 2'd0, 1'b0, 2'd1);

      run_rows(16, 29);

      repeat (3) strobe_a(13'd2200);
      do_reset();
      for (int i = 0; i < 4; i++) begin
         strobe_a(13'd2200);
         if (i == 2) chk_all("rst_relock3", 2'd1, 1'b0, 2'd0);
      end
      chk_all("rst_relock4", 2'd2, 1'b1, 2'd1);

      repeat (TMO - 1) @(posedge clk);
      #1;
      strobe_a(13'd2200);
      chk("collision state", 32'(st), 32'd2);
      repeat (TMO - 1) @(posedge clk);
      #1;
      chk("collision cleared", 32'(st), 32'd2);

      do_reset();
      for (int i = 0; i < 8; i++) begin
         strobe_a((i % 2 == 1) ? 13'd2201 : 13'd2200);
`ifdef VIDEO_LOCK_TOL_EN
         chk($sformatf("jit%0d state", i), 32'(st), (i < 3) ? 32'd1 : 32'd2);
         chk($sformatf("jit%0d fc", i), 32'(fc), 32'(i == 3));
`else
         chk($sformatf("jit%0d state", i), 32'(st), 32'd1);
         chk($sformatf("jit%0d fc", i), 32'(fc), 32'd0);
`endif
      end
`ifdef VIDEO_LOCK_TOL_EN
      chk("jit hs_lk", 32'(hl), 32'd2200);
`else
      chk("jit hs_lk", 32'(hl), 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
